pwm_peripheral: RTL and testbench

- Downstream consumer of the SPI register block; turns the five SPI-written control bytes into 16 registered output pins.
- Per channel: forced low, forced high, or driven by one shared PWM waveform.
- PWM waveform comes from a clock prescaler and an 8-bit period counter.
- A shadow duty register is updated only at period boundaries, so SPI writes never produce runt pulses.

---
 rtl/pwm_peripheral.sv | 76 +++++++
 tb/tb_pwm_peripheral.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_peripheral.sv
// Sixteen-channel PWM output stage driven by SPI control bytes.
// Each channel is forced low, forced high, or follows one shared PWM waveform; all outputs are registered.
module pwm_peripheral #(
    parameter int CLK_DIV = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        pwm_period_start
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [7:0]    CNT_LAST   = 8'd254;

    logic [PW-1:0] prescaler_reg;
    logic [PW-1:0] prescaler_next;
    logic [7:0]    counter_reg;
    logic [7:0]    counter_next;
    logic [7:0]    duty_shadow_reg;
    logic [7:0]    duty_eff;
    logic          tick;
    logic          period_first;
    logic          pwm_raw;
    logic [15:0]   en_out;
    logic [15:0]   en_pwm;
    logic [15:0]   out_next;

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    always_comb begin
        tick           = (prescaler_reg == PRESC_LAST);
        prescaler_next = tick ? '0 : prescaler_reg + PW'(1);
        counter_next   = counter_reg;
        if (tick) begin
            // The counter stops at 254 so a duty of 0xFF keeps the output high all period.
            counter_next = (counter_reg == CNT_LAST) ? 8'd0 : counter_reg + 8'd1;
        end
    end

    // The duty on the first cycle of a period holds for the whole period, avoiding runt pulses.
    always_comb begin
        period_first = (prescaler_reg == '0) && (counter_reg == 8'd0);
        duty_eff     = period_first ? pwm_duty_cycle : duty_shadow_reg;
        pwm_raw      = (counter_reg < duty_eff);
    end

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_chan
            assign out_next[gi] = en_out[gi] ? (en_pwm[gi] ? pwm_raw : 1'b1) : 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler_reg    <= '0;
            counter_reg      <= 8'd0;
            duty_shadow_reg  <= 8'd0;
            out              <= 16'h0000;
            pwm_period_start <= 1'b0;
        end else begin
            prescaler_reg    <= prescaler_next;
            counter_reg      <= counter_next;
            duty_shadow_reg  <= duty_eff;
            out              <= out_next;
            pwm_period_start <= period_first;
        end
    end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Bench for pwm_peripheral: two instances (CLK_DIV 1 and 2) checked every cycle against a time-based model,
// plus directed scenarios with hand-computed expectations and a randomized phase.
module tb_pwm_peripheral;

    logic        clk;
    logic        rst;
    logic [15:0] en_out_tb;
    logic [15:0] en_pwm_tb;
    logic [7:0]  duty;
    logic [15:0] out_d1, out_d2;
    logic        ps_d1, ps_d2;

    int n_checks = 0;
    int n_fail   = 0;

    pwm_peripheral #(.CLK_DIV(1)) dut_d1 (
        .clk(clk), .rst(rst),
        .en_reg_out_7_0(en_out_tb[7:0]), .en_reg_out_15_8(en_out_tb[15:8]),
        .en_reg_pwm_7_0(en_pwm_tb[7:0]), .en_reg_pwm_15_8(en_pwm_tb[15:8]),
        .pwm_duty_cycle(duty), .out(out_d1), .pwm_period_start(ps_d1)
    );

    pwm_peripheral #(.CLK_DIV(2)) dut_d2 (
        .clk(clk), .rst(rst),
        .en_reg_out_7_0(en_out_tb[7:0]), .en_reg_out_15_8(en_out_tb[15:8]),
        .en_reg_pwm_7_0(en_pwm_tb[7:0]), .en_reg_pwm_15_8(en_pwm_tb[15:8]),
        .pwm_duty_cycle(duty), .out(out_d2), .pwm_period_start(ps_d2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: time since reset release determines counter and period start; duty is latched at each period start.
    int          t_m   [2];
    logic [7:0]  cap_m [2];
    logic [15:0] exp_out [2];
    logic        exp_ps  [2];
    bit          model_valid = 0;

    always @(posedge clk) begin : model
        int  div;
        int  cnt;
        bit  pf;
        bit  pwm;
        for (int k = 0; k < 2; k++) begin
            div = k + 1;
            if (rst) begin
                t_m[k]     = 0;
                cap_m[k]   = 8'd0;
                exp_out[k] <= 16'h0000;
                exp_ps[k]  <= 1'b0;
            end else begin
                cnt = (t_m[k] / div) % 255;
                pf  = (t_m[k] % (255 * div)) == 0;
                if (pf) cap_m[k] = duty;
                pwm = cnt < int'(cap_m[k]);
                exp_out[k] <= en_out_tb & (~en_pwm_tb | {16{pwm}});
                exp_ps[k]  <= pf;
                t_m[k]     = t_m[k] + 1;
            end
        end
        if (rst) model_valid <= 1'b1;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("model_out_d1", out_d1, exp_out[0]);
            check("model_ps_d1", {15'd0, ps_d1}, {15'd0, exp_ps[0]});
            check("model_out_d2", out_d2, exp_out[1]);
            check("model_ps_d2", {15'd0, ps_d2}, {15'd0, exp_ps[1]});
        end
    end

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    int hi_cnt;
    int lo_cnt;
    int ps_cnt;

    initial begin
        rst       = 1'b1;
        en_out_tb = 16'hFFFF;
        en_pwm_tb = 16'hFFFF;
        duty      = 8'h80;

        // Reset held for three cycles with everything enabled
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_out", out_d2, 16'h0000);
            check("reset_ps", {15'd0, ps_d2}, 16'h0000);
        end
        rst = 1'b0;
        @(negedge clk);
        check("first_period_ps", {15'd0, ps_d1}, 16'h0001);
        @(negedge clk);
        check("ps_one_cycle", {15'd0, ps_d1}, 16'h0000);
        $display("reset: done, out=%h", out_d2);

        // Static enables
        en_out_tb = 16'hFFFF; en_pwm_tb = 16'h0000;
        @(negedge clk);
        check("static_ffff", out_d1, 16'hFFFF);
        en_out_tb = 16'h00FF;
        @(negedge clk);
        check("static_00ff", out_d1, 16'h00FF);
        $display("static enables: out=%h", out_d1);

        // 50% duty on the CLK_DIV=2 instance
        rst = 1'b1; en_out_tb = 16'h0001; en_pwm_tb = 16'h0001; duty = 8'h80;
        @(negedge clk);
        rst = 1'b0;
        hi_cnt = 0; ps_cnt = 0;
        for (int i = 0; i < 1020; i++) begin
            @(negedge clk);
            if (i < 510 && out_d2[0]) hi_cnt++;
            if (ps_d2) ps_cnt++;
            if (i == 0 || i == 510) begin
                check("duty50_ps_at_start", {15'd0, ps_d2}, 16'h0001);
                check("duty50_rise_at_start", {15'd0, out_d2[0]}, 16'h0001);
            end
            if (i == 256) check("duty50_fall", {15'd0, out_d2[0]}, 16'h0000);
        end
        check("duty50_high_cycles", 16'(hi_cnt), 16'd256);
        check("duty50_ps_count", 16'(ps_cnt), 16'd2);
        $display("duty 50%%: high=%0d ps=%0d", hi_cnt, ps_cnt);

        // Extremes
        rst = 1'b1; duty = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        hi_cnt = 0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (out_d2[0]) hi_cnt++;
        end
        check("duty00_high_cycles", 16'(hi_cnt), 16'd0);
        rst = 1'b1; duty = 8'hFF;
        @(negedge clk);
        rst = 1'b0;
        lo_cnt = 0;
        for (int i = 0; i < 3 * 510 + 10; i++) begin
            @(negedge clk);
            if (!out_d2[0]) lo_cnt++;
        end
        check("dutyff_low_cycles", 16'(lo_cnt), 16'd0);
        $display("extremes: high@00=%0d low@ff=%0d", hi_cnt, lo_cnt);

        // Mid-period duty change on the CLK_DIV=1 instance
        rst = 1'b1; duty = 8'h40;
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        duty = 8'hC0;
        hi_cnt = 0;
        for (int i = 100; i < 255; i++) begin
            @(negedge clk);
            if (out_d1[0]) hi_cnt++;
        end
        check("midchange_rest_of_period", 16'(hi_cnt), 16'd0);
        hi_cnt = 0;
        for (int i = 255; i < 510; i++) begin
            @(negedge clk);
            if (out_d1[0]) hi_cnt++;
            if (i == 255) check("midchange_next_ps", {15'd0, ps_d1}, 16'h0001);
            if (i == 446) check("midchange_last_high", {15'd0, out_d1[0]}, 16'h0001);
            if (i == 447) check("midchange_first_low", {15'd0, out_d1[0]}, 16'h0000);
        end
        check("midchange_next_high", 16'(hi_cnt), 16'd192);
        $display("mid-period change: next period high=%0d", hi_cnt);

        // Mixed channel map and reset mid-period
        rst = 1'b1; en_out_tb = 16'h0F0F; en_pwm_tb = 16'h00FF; duty = 8'h20;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (i == 10)  check("mixed_high_phase", out_d1, 16'h0F0F);
            if (i == 100) check("mixed_low_phase", out_d1, 16'h0F00);
        end
        rst = 1'b1; duty = 8'h10;
        @(negedge clk);
        check("midreset_out_d1", out_d1, 16'h0000);
        check("midreset_out_d2", out_d2, 16'h0000);
        check("midreset_ps", {15'd0, ps_d1}, 16'h0000);
        rst = 1'b0;
        @(negedge clk);
        check("restart_ps", {15'd0, ps_d1}, 16'h0001);
        check("restart_out", out_d1, 16'h0F0F);
        repeat (20) @(negedge clk);
        check("recapture_d1", out_d1, 16'h0F00);
        check("recapture_d2", out_d2, 16'h0F0F);
        $display("mixed map: out_d1=%h out_d2=%h", out_d1, out_d2);

        // Randomized enables, duty writes and occasional resets
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 15) == 0) begin
                en_out_tb = 16'($urandom);
                en_pwm_tb = 16'($urandom);
            end
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 3))
                    0:       duty = 8'h00;
                    1:       duty = 8'hFF;
                    default: duty = 8'($urandom);
                endcase
            end
            @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);
        $display("random phase: %0d cycles", 4000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
